conv3x3_stream: RTL and testbench

CONV3X3_STREAM -- requirements
Module: conv3x3_stream

---
 rtl/conv3x3_stream_if.sv | 31 +++
 rtl/conv3x3_stream.sv | 168 ++++++++++++++++
 tb/tb_conv3x3_stream.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv3x3_stream_if.sv
// conv3x3_stream_if: control, coefficient and pixel stream
// bundle shared by the filter (slave) and its driver (master).
interface conv3x3_stream_if #(
   parameter int PIX_W  = 8,
   parameter int COEF_W = 8
);
   logic              mode;
   logic              coef_we;
   logic [3:0]        coef_idx;
   logic [COEF_W-1:0] coef_data;
   logic              in_valid;
   logic              in_ready;
   logic              in_sof;
   logic [PIX_W-1:0]  in_pixel;
   logic              out_valid;
   logic              out_ready;
   logic              out_eol;
   logic [PIX_W-1:0]  out_pixel;

   modport master (
      output mode, coef_we, coef_idx, coef_data,
      output in_valid, in_sof, in_pixel, out_ready,
      input  in_ready, out_valid, out_eol, out_pixel
   );

   modport slave (
      input  mode, coef_we, coef_idx, coef_data,
      input  in_valid, in_sof, in_pixel, out_ready,
      output in_ready, out_valid, out_eol, out_pixel
   );
endinterface

// File: rtl/conv3x3_stream.sv
// conv3x3_stream: raster-order 3x3 convolution with bypass,
// two line buffers, window/multiply then sum/clamp/output.
module conv3x3_stream #(
   parameter int IMG_W  = 64,
   parameter int PIX_W  = 8,
   parameter int COEF_W = 8,
   parameter int SHIFT  = 4
) (
   input logic             clk,
   input logic             rst,
   conv3x3_stream_if.slave bus
);
   localparam int CW = $clog2(IMG_W);
   localparam int PW = PIX_W + COEF_W + 1;
   localparam int AW = PIX_W + COEF_W + 4;
   localparam logic [CW-1:0] LAST = CW'(IMG_W - 1);
   localparam logic signed [AW-1:0] MAXV = AW'((1 << PIX_W) - 1);

   logic [CW-1:0]            r_col;
   logic [1:0]               r_row;
   logic [PIX_W-1:0]         r_lb0 [0:IMG_W-1];
   logic [PIX_W-1:0]         r_lb1 [0:IMG_W-1];
   logic [PIX_W-1:0]         r_win [0:8];
   logic signed [COEF_W-1:0] r_coef [0:8];
   logic                     r_v0;
   logic                     r_eol0;
   logic signed [PW-1:0]     r_prod [0:8];
   logic [PIX_W-1:0]         r_ctr1;
   logic                     r_mode1;
   logic                     r_v1;
   logic                     r_eol1;
   logic                     r_out_valid;
   logic                     r_out_eol;
   logic [PIX_W-1:0]         r_out_pixel;

   logic                     w_stall;
   logic                     w_ready;
   logic                     w_xfer;
   logic [CW-1:0]            w_col;
   logic [1:0]               w_row;
   logic                     w_emit;
   logic [PIX_W-1:0]         w_top;
   logic [PIX_W-1:0]         w_mid;
   logic signed [AW-1:0]     w_sum;
   logic signed [AW-1:0]     w_shr;
   logic [PIX_W-1:0]         w_clamp;

   assign w_stall = r_out_valid && !bus.out_ready;
   assign w_ready = !rst && !w_stall;
   assign w_xfer  = bus.in_valid && w_ready;
   assign w_col   = bus.in_sof ? '0 : r_col;
   assign w_row   = bus.in_sof ? 2'd0 : r_row;
   assign w_emit  = (w_row == 2'd2) && (w_col >= CW'(2));
   assign w_top   = r_lb1[w_col];
   assign w_mid   = r_lb0[w_col];

   assign bus.in_ready  = w_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_eol   = r_out_eol;
   assign bus.out_pixel = r_out_pixel;

   // Raster position; sof forces the pixel to col 0, row 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_xfer) begin
         if (w_col == LAST) begin
            r_col <= '0;
            r_row <= (w_row == 2'd2) ? 2'd2 : w_row + 2'd1;
         end else begin
            r_col <= w_col + CW'(1);
            r_row <= w_row;
         end
      end
   end

   // Line buffers: old line moves up before the new pixel lands.
   always_ff @(posedge clk) begin
      if (w_xfer) begin
         r_lb1[w_col] <= w_mid;
         r_lb0[w_col] <= bus.in_pixel;
      end
   end

   // 3x3 window shifts left by one column per accepted pixel.
   always_ff @(posedge clk) begin
      if (w_xfer) begin
         r_win[0] <= r_win[1];
         r_win[1] <= r_win[2];
         r_win[2] <= w_top;
         r_win[3] <= r_win[4];
         r_win[4] <= r_win[5];
         r_win[5] <= w_mid;
         r_win[6] <= r_win[7];
         r_win[7] <= r_win[8];
         r_win[8] <= bus.in_pixel;
      end
   end

   // Window-stage tags: emit only inside the valid output region.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_v0   <= 1'b0;
         r_eol0 <= 1'b0;
      end else if (!w_stall) begin
         r_v0   <= w_xfer && w_emit;
         r_eol0 <= w_xfer && (w_col == LAST);
      end
   end

   // Coefficient file; reset loads the identity kernel.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 9; k++) begin
            if (k == 4) r_coef[k] <= COEF_W'(1 << SHIFT);
            else        r_coef[k] <= '0;
         end
      end else if (bus.coef_we && bus.coef_idx < 4'd9) begin
         r_coef[bus.coef_idx] <= bus.coef_data;
      end
   end

   // Multiply stage: signed coefficient times unsigned pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1    <= 1'b0;
         r_eol1  <= 1'b0;
         r_mode1 <= 1'b0;
         r_ctr1  <= '0;
         for (int k = 0; k < 9; k++) r_prod[k] <= '0;
      end else if (!w_stall) begin
         r_v1    <= r_v0;
         r_eol1  <= r_eol0;
         r_mode1 <= bus.mode;
         r_ctr1  <= r_win[4];
         for (int k = 0; k < 9; k++) begin
            r_prod[k] <= PW'(r_coef[k])
                       * PW'($signed({1'b0, r_win[k]}));
         end
      end
   end

   // Sum, scale and clamp the products to the pixel range.
   always_comb begin
      w_sum = '0;
      for (int k = 0; k < 9; k++) w_sum = w_sum + AW'(r_prod[k]);
      w_shr = w_sum >>> SHIFT;
      if (w_shr[AW-1])      w_clamp = '0;
      else if (w_shr > MAXV) w_clamp = '1;
      else                  w_clamp = w_shr[PIX_W-1:0];
   end

   // Output register; frozen while downstream stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_eol   <= 1'b0;
         r_out_pixel <= '0;
      end else if (!w_stall) begin
         r_out_valid <= r_v1;
         if (r_v1) begin
            r_out_pixel <= r_mode1 ? r_ctr1 : w_clamp;
            r_out_eol   <= r_eol1;
         end
      end
   end
endmodule

// File: tb/tb_conv3x3_stream.sv
// tb_conv3x3_stream: table vectors, hand sequences and random
// frames checked against an image-array reference model.
module tb_conv3x3_stream;
   localparam int IMG_W  = 8;
   localparam int PIX_W  = 8;
   localparam int COEF_W = 8;
   localparam int SHIFT  = 4;

   typedef struct {
      int pix;
      int eol;
   } exp_t;

   typedef struct {
      int fill;
      int c4;
      int pix;
      int expv;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   conv3x3_stream_if #(.PIX_W(PIX_W), .COEF_W(COEF_W)) bus();

   conv3x3_stream #(
      .IMG_W (IMG_W),
      .PIX_W (PIX_W),
      .COEF_W(COEF_W),
      .SHIFT (SHIFT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int   checks = 0;
   int   errors = 0;
   int   n_out  = 0;
   int   coef_m [9];
   int   img [64][IMG_W];
   int   ml = 0;
   int   mc = 0;
   int   mode_m = 0;
   int   tbl_on = 0;
   int   tbl_exp = 0;
   exp_t expq [$];
   vec_t vecs [6];
   logic bp_en = 1'b0;
   logic or_force = 1'b1;
   logic r_rand = 1'b1;

   assign bus.out_ready = bp_en ? r_rand : or_force;

   // Random downstream back-pressure, changed away from the edge.
   always @(posedge clk) begin
      #1;
      r_rand = ($urandom_range(0, 3) != 0);
   end

   task automatic check(input string name, input int act,
                        input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Output monitor: every accepted output is scored in order.
   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst && bus.out_valid && bus.out_ready) begin
         n_out++;
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=%0d required=none",
                     bus.out_pixel);
         end else begin
            e = expq.pop_front();
            check("out_pixel", int'(bus.out_pixel), e.pix);
            check("out_eol", int'(bus.out_eol), e.eol);
         end
      end
   end

   function automatic void model_reset_coef();
      for (int k = 0; k < 9; k++) coef_m[k] = (k == 4) ? 16 : 0;
   endfunction

   // Reference: keep the frame as an image and filter directly.
   function automatic void model_accept(input int pix, input bit sof);
      int   s;
      int   v;
      exp_t e;
      if (sof) begin
         ml = 0;
         mc = 0;
      end
      img[ml][mc] = pix;
      if (ml >= 2 && mc >= 2) begin
         if (mode_m != 0) begin
            v = img[ml-1][mc-1];
         end else begin
            s = 0;
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  s += coef_m[3*i+j] * img[ml-2+i][mc-2+j];
            v = s >>> SHIFT;
            if (v < 0) v = 0;
            if (v > 255) v = 255;
         end
         if (tbl_on != 0) v = tbl_exp;
         e.pix = v;
         e.eol = (mc == IMG_W - 1) ? 1 : 0;
         expq.push_back(e);
      end
      mc++;
      if (mc == IMG_W) begin
         mc = 0;
         ml++;
      end
   endfunction

   task automatic send_pixel(input int pix, input bit sof,
                             input bit gaps);
      int t;
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      bus.in_valid = 1'b1;
      bus.in_pixel = 8'(pix);
      bus.in_sof   = sof;
      t = 0;
      forever begin
         @(negedge clk);
         if (bus.in_ready) break;
         t++;
         if (t > 300) begin
            $display("FAIL in_ready_timeout actual=0 required=1");
            $fatal(1, "input handshake timeout");
         end
      end
      @(posedge clk);
      model_accept(pix, sof);
      #1;
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
   endtask

   task automatic send_frame(input int kind, input int val,
                             input int lines, input bit gaps);
      int p;
      for (int r = 0; r < lines; r++) begin
         for (int c = 0; c < IMG_W; c++) begin
            if (kind == 0)      p = 8 * r + c;
            else if (kind == 1) p = val;
            else                p = int'($urandom_range(0, 255));
            send_pixel(p, (r == 0 && c == 0), gaps);
         end
      end
   endtask

   task automatic write_coef(input int idx, input int val);
      bus.coef_we   = 1'b1;
      bus.coef_idx  = 4'(idx);
      bus.coef_data = 8'(val);
      @(posedge clk);
      #1;
      bus.coef_we = 1'b0;
      if (idx < 9) coef_m[idx] = val;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (expq.size() != 0 && t < 400) begin
         @(posedge clk);
         t++;
      end
      check("drain_empty", expq.size(), 0);
      expq.delete();
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      int base;
      int held;
      int nl;
      vecs[0] = '{1,   1, 144,  81};
      vecs[1] = '{0, -16, 100,   0};
      vecs[2] = '{0, 127, 100, 255};
      vecs[3] = '{0,  16,  77,  77};
      vecs[4] = '{0,   8, 200, 100};
      vecs[5] = '{1,   1, 255, 143};

      bus.mode      = 1'b0;
      bus.coef_we   = 1'b0;
      bus.coef_idx  = '0;
      bus.coef_data = '0;
      bus.in_valid  = 1'b0;
      bus.in_sof    = 1'b0;
      bus.in_pixel  = '0;
      model_reset_coef();

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_out_pixel", int'(bus.out_pixel), 0);
      check("rst_out_eol", int'(bus.out_eol), 0);
      check("rst_in_ready", int'(bus.in_ready), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", int'(bus.in_ready), 1);
      @(posedge clk);
      #1;

      // Identity ramp; an out-of-range index write must be ignored.
      write_coef(9, 55);
      write_coef(15, -3);
      base = n_out;
      send_frame(0, 0, 4, 1'b0);
      drain();
      check("ramp_count", n_out - base, 12);

      // Constant frames against tabulated results.
      for (int v = 0; v < 6; v++) begin
         for (int k = 0; k < 9; k++) begin
            if (vecs[v].fill != 0) write_coef(k, 1);
            else write_coef(k, (k == 4) ? vecs[v].c4 : 0);
         end
         tbl_on  = 1;
         tbl_exp = vecs[v].expv;
         base = n_out;
         send_frame(1, vecs[v].pix, 4, 1'b0);
         drain();
         tbl_on = 0;
         check("table_count", n_out - base, 12);
      end

      // Stall during the third line.
      for (int k = 0; k < 9; k++) write_coef(k, (k == 4) ? 16 : k - 3);
      base = n_out;
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < IMG_W; c++)
            send_pixel(int'($urandom_range(0, 255)), (r == 0 && c == 0), 0);
      for (int c = 0; c < 5; c++)
         send_pixel(int'($urandom_range(0, 255)), 1'b0, 1'b0);
      or_force = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_pixel = 8'd99;
      @(negedge clk);
      check("stall_out_valid", int'(bus.out_valid), 1);
      held = int'(bus.out_pixel);
      for (int i = 0; i < 5; i++) begin
         check("stall_in_ready", int'(bus.in_ready), 0);
         check("stall_out_pixel", int'(bus.out_pixel), held);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      or_force = 1'b1;
      send_pixel(99, 1'b0, 1'b0);
      for (int c = 6; c < IMG_W; c++)
         send_pixel(int'($urandom_range(0, 255)), 1'b0, 1'b0);
      for (int c = 0; c < IMG_W; c++)
         send_pixel(int'($urandom_range(0, 255)), 1'b0, 1'b0);
      drain();
      check("stall_count", n_out - base, 12);

      // sof mid-line restarts the frame.
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < IMG_W; c++)
            send_pixel(int'($urandom_range(0, 255)), (r == 0 && c == 0), 0);
      for (int c = 0; c < 5; c++)
         send_pixel(int'($urandom_range(0, 255)), 1'b0, 1'b0);
      drain();
      base = n_out;
      for (int i = 0; i < 2 * IMG_W + 2; i++)
         send_pixel(int'($urandom_range(0, 255)), (i == 0), 1'b0);
      repeat (5) @(posedge clk);
      #1;
      check("sof_no_early", n_out - base, 0);
      for (int i = 2; i < 2 * IMG_W; i++)
         send_pixel(int'($urandom_range(0, 255)), 1'b0, 1'b0);
      drain();
      check("sof_count", n_out - base, 12);

      // Reset with two outputs in flight.
      for (int k = 0; k < 9; k++) write_coef(k, 1);
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < IMG_W; c++)
            send_pixel(int'($urandom_range(0, 255)), (r == 0 && c == 0), 0);
      for (int c = 0; c < 4; c++)
         send_pixel(int'($urandom_range(0, 255)), 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      expq.delete();
      model_reset_coef();
      @(negedge clk);
      check("midrst_out_valid", int'(bus.out_valid), 0);
      check("midrst_out_pixel", int'(bus.out_pixel), 0);
      check("midrst_in_ready", int'(bus.in_ready), 1);
      @(posedge clk);
      #1;
      base = n_out;
      send_frame(2, 0, 4, 1'b0);
      drain();
      check("midrst_count", n_out - base, 12);

      // Random frames, coefficients, mode, gaps and back-pressure.
      bp_en = 1'b1;
      for (int f = 0; f < 8; f++) begin
         for (int k = 0; k < 10; k++)
            write_coef(int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 255)) - 128);
         mode_m   = int'($urandom_range(0, 3) == 0);
         bus.mode = mode_m[0];
         nl = 3 + (f % 3);
         base = n_out;
         send_frame(2, 0, nl, 1'b1);
         drain();
         check("rand_count", n_out - base, (nl - 2) * (IMG_W - 2));
      end
      bp_en    = 1'b0;
      bus.mode = 1'b0;
      mode_m   = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
